// File: rtl/pipe_stage_skid.sv
// Parametrised pipeline stage register with valid/ready handshake, optional skid
// entry, flush and a saturating stall counter.
module pipe_stage_skid #(
    parameter int unsigned DATA_W = 197,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_FULL  = 2'd1,
        S_SKID  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  main_q, main_d;
    logic [DATA_W-1:0]  skid_q, skid_d;
    logic               accept, consume;

    assign out_valid = (state_q != S_EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    // Single-entry mode never reaches S_SKID: in_ready is low whenever full and
    // not draining, so the shared state machine covers both variants.
    if (SKID != 0) begin : g_skid
        assign in_ready = (state_q != S_SKID);
    end else begin : g_noskid
        assign in_ready = !out_valid || out_ready;
    end

    always_comb begin
        unique case (state_q)
            S_EMPTY: occupancy = 2'd0;
            S_FULL:  occupancy = 2'd1;
            S_SKID:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = S_EMPTY;
            main_d  = '0;
            skid_d  = '0;
        end else begin
            unique case (state_q)
                S_EMPTY: begin
                    if (accept) begin
                        main_d  = in_data;
                        state_d = S_FULL;
                    end
                end
                S_FULL: begin
                    if (accept && consume) begin
                        main_d = in_data;
                    end else if (accept) begin
                        skid_d  = in_data;
                        state_d = S_SKID;
                    end else if (consume) begin
                        main_d  = '0;
                        state_d = S_EMPTY;
                    end
                end
                S_SKID: begin
                    if (consume) begin
                        main_d  = skid_q;
                        skid_d  = '0;
                        state_d = S_FULL;
                    end
                end
                default: begin
                    state_d = S_EMPTY;
                    main_d  = '0;
                    skid_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule
